// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds the FSM state type, the bus widths and the index-width helper.
package wb_arbiter_pkg;

  localparam int WB_ARB_MAX_INITIATORS = 4;
  localparam int WB_ADDR_WIDTH = 24;
  localparam int DATA_WIDTH = 16;

  localparam int OUTS_MAX = 16;
  localparam int OUTS_W = $clog2(OUTS_MAX) + 1;

  typedef enum logic [1:0] {
    WB_ARB_IDLE,
    WB_ARB_OWNED,
    WB_ARB_DRAIN
  } wb_arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Initiator-side and target-side Wishbone signals of the arbiter.
// slave: the arbiter's view; master: the surrounding initiators/targets.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int N = 2
);

  localparam int OW = idx_width(N);

  logic [N-1:0][WB_ADDR_WIDTH-1:0] ini_addr_i;
  logic [N-1:0][DATA_WIDTH-1:0]    ini_data_i;
  logic [N-1:0][DATA_WIDTH-1:0]    ini_data_o;
  logic [N-1:0]                    ini_we_i;
  logic [N-1:0]                    ini_cycle_i;
  logic [N-1:0]                    ini_strobe_i;
  logic [N-1:0]                    ini_stall_o;
  logic [N-1:0]                    ini_ack_o;

  logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
  logic [DATA_WIDTH-1:0]    wb_data_o;
  logic [DATA_WIDTH-1:0]    wb_data_i;
  logic                     wb_we_o;
  logic                     wb_cycle_o;
  logic                     wb_strobe_o;
  logic                     wb_stall_i;
  logic                     wb_ack_i;

  logic [OW-1:0] owner_o;
  logic          owner_valid_o;
  logic          timeout_o;

  modport slave (
    input  ini_addr_i,
    input  ini_data_i,
    output ini_data_o,
    input  ini_we_i,
    input  ini_cycle_i,
    input  ini_strobe_i,
    output ini_stall_o,
    output ini_ack_o,
    output wb_addr_o,
    output wb_data_o,
    input  wb_data_i,
    output wb_we_o,
    output wb_cycle_o,
    output wb_strobe_o,
    input  wb_stall_i,
    input  wb_ack_i,
    output owner_o,
    output owner_valid_o,
    output timeout_o
  );

  modport master (
    output ini_addr_i,
    output ini_data_i,
    input  ini_data_o,
    output ini_we_i,
    output ini_cycle_i,
    output ini_strobe_i,
    input  ini_stall_o,
    input  ini_ack_o,
    input  wb_addr_o,
    input  wb_data_o,
    output wb_data_i,
    input  wb_we_o,
    input  wb_cycle_o,
    input  wb_strobe_o,
    output wb_stall_i,
    output wb_ack_i,
    input  owner_o,
    input  owner_valid_o,
    input  timeout_o
  );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after the last
// winner, wrapping N-1 -> 0.
module wb_arbiter_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int j;
  logic [IW-1:0] jj;

  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    j = 0;
    jj = '0;
    for (int i = 1; i <= N; i++) begin
      j = int'(last) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any = 1'b1;
        grant_idx = jj;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter, ownership held per CYC.
// Optional ACK watchdog with DRAIN state: define WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_INITIATORS = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic        wb_clock_i,
  input logic        wb_reset_i,
  wb_arbiter_if.slave bus
);

  localparam int N  = NUM_INITIATORS;
  localparam int OW = idx_width(N);
  localparam logic [OUTS_W-1:0] OUTS_FULL =
    OUTS_W'(OUTS_MAX);

  if (N < 1 || N > WB_ARB_MAX_INITIATORS ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_arbiter: bad parameters");
  end

  wb_arb_state_t state_q, state_d;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] last_q;
  logic [OW-1:0] pick_idx;
  logic          pick_any;
  logic [OUTS_W-1:0] outs_q;

  logic owned;
  logic own_cyc;
  logic own_stb;
  logic inc;
  logic dec;
  logic wd_hit;

  logic [N-1:0] stall_v;
  logic [N-1:0] ack_v;

  wb_arbiter_rr_picker #(
    .N (N),
    .IW(OW)
  ) u_pick (
    .req      (bus.ini_cycle_i),
    .last     (last_q),
    .grant_idx(pick_idx),
    .any      (pick_any)
  );

  assign owned   = (state_q == WB_ARB_OWNED);
  assign own_cyc = bus.ini_cycle_i[owner_q];
  assign own_stb = bus.ini_strobe_i[owner_q];

  assign inc = owned & own_cyc & own_stb &
               ~bus.wb_stall_i;
  assign dec = owned & bus.wb_ack_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // Fires on the count that would reach TIMEOUT_CYCLES.
  assign wd_hit = owned & own_cyc &
                  (outs_q != '0) & ~bus.wb_ack_i &
                  (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_hit;
      if (!owned || bus.wb_ack_i) begin
        wd_q <= '0;
      end else if (outs_q != '0) begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign wd_hit = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_ARB_IDLE: begin
        if (pick_any) state_d = WB_ARB_OWNED;
      end
      WB_ARB_OWNED: begin
        if (!own_cyc) state_d = WB_ARB_IDLE;
        else if (wd_hit) state_d = WB_ARB_DRAIN;
      end
`ifdef WB_ARB_TIMEOUT_EN
      WB_ARB_DRAIN: begin
        if (!own_cyc) state_d = WB_ARB_IDLE;
      end
`endif
      default: state_d = WB_ARB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q <= WB_ARB_IDLE;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WB_ARB_IDLE && pick_any) begin
        owner_q <= pick_idx;
      end
      if (state_q != WB_ARB_IDLE &&
          state_d == WB_ARB_IDLE) begin
        last_q <= owner_q;
      end
      if (state_d == WB_ARB_IDLE) begin
        outs_q <= '0;
      end else if (inc && !dec) begin
        if (outs_q != OUTS_FULL) outs_q <= outs_q + 1'b1;
      end else if (dec && !inc) begin
        if (outs_q != '0) outs_q <= outs_q - 1'b1;
      end
    end
  end

  // Non-owners always see stall and never see ack.
  always_comb begin
    stall_v = '1;
    ack_v   = '0;
    if (owned) begin
      stall_v[owner_q] = bus.wb_stall_i;
      ack_v[owner_q]   = bus.wb_ack_i;
    end
  end

  assign bus.ini_stall_o = stall_v;
  assign bus.ini_ack_o   = ack_v;
  assign bus.ini_data_o  = {N{bus.wb_data_i}};

  assign bus.wb_cycle_o  = owned & own_cyc;
  assign bus.wb_strobe_o = owned & own_cyc & own_stb;
  assign bus.wb_we_o     = owned & bus.ini_we_i[owner_q];
  assign bus.wb_addr_o   = owned ?
    bus.ini_addr_i[owner_q] : '0;
  assign bus.wb_data_o   = owned ?
    bus.ini_data_i[owner_q] : '0;

  assign bus.owner_o       = owner_q;
  assign bus.owner_valid_o = (state_q != WB_ARB_IDLE);

`ifndef SYNTHESIS
  a_outs_sat: assert property (
    @(posedge wb_clock_i) disable iff (wb_reset_i)
    !(outs_q == OUTS_FULL && inc && !dec))
    else $error("wb_arbiter: outstanding overflow");

  a_early_drop: assert property (
    @(posedge wb_clock_i) disable iff (wb_reset_i)
    !(owned && !own_cyc && outs_q != '0))
    else $error("wb_arbiter: CYC dropped with outstanding");
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected grants/acks are queued by
// the stimulus and popped by a negedge monitor.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_arbiter_if #(.N(N)) bus ();

  wb_arbiter #(
    .NUM_INITIATORS(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clock_i(clk),
    .wb_reset_i(rst),
    .bus       (bus)
  );

  typedef struct {
    string                 name;
    logic [N-1:0]          ack;
    logic [DATA_WIDTH-1:0] data;
  } ack_exp_t;

  typedef struct {
    string name;
    int    owner;
  } gnt_exp_t;

  ack_exp_t ack_q[$];
  gnt_exp_t gnt_q[$];

  int checks = 0;
  int failures = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    ack_exp_t ae;
    gnt_exp_t ge;
    int k;
    if (|bus.ini_ack_o) begin
      if (ack_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=%b required=none",
                 bus.ini_ack_o);
      end else begin
        ae = ack_q.pop_front();
        k = ae.ack[1] ? 1 : 0;
        chk({ae.name, "_ack"}, 32'(bus.ini_ack_o),
            32'(ae.ack));
        chk({ae.name, "_rdata"}, 32'(bus.ini_data_o[k]),
            32'(ae.data));
      end
    end
    if (bus.owner_valid_o && !prev_valid) begin
      if (gnt_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant actual=%0d required=none",
                 bus.owner_o);
      end else begin
        ge = gnt_q.pop_front();
        chk(ge.name, 32'(bus.owner_o), 32'(ge.owner));
      end
    end
    prev_valid <= bus.owner_valid_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_ini(input int i, input logic c,
                         input logic s, input logic w,
                         input logic [WB_ADDR_WIDTH-1:0] a,
                         input logic [DATA_WIDTH-1:0] d);
    bus.ini_cycle_i[i]  = c;
    bus.ini_strobe_i[i] = s;
    bus.ini_we_i[i]     = w;
    bus.ini_addr_i[i]   = a;
    bus.ini_data_i[i]   = d;
  endtask

  task automatic tgt(input logic ack, input logic stall,
                     input logic [DATA_WIDTH-1:0] d);
    bus.wb_ack_i   = ack;
    bus.wb_stall_i = stall;
    bus.wb_data_i  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_ini(i, 0, 0, 0, '0, '0);
    tgt(0, 0, '0);
  endtask

  task automatic push_ack(input string n,
                          input logic [N-1:0] a,
                          input logic [DATA_WIDTH-1:0] d);
    ack_exp_t e;
    e.name = n;
    e.ack  = a;
    e.data = d;
    ack_q.push_back(e);
  endtask

  task automatic push_gnt(input string n, input int o);
    gnt_exp_t e;
    e.name  = n;
    e.owner = o;
    gnt_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear_all();
    at_neg();
    chk("rst_valid", 32'(bus.owner_valid_o), 0);
    chk("rst_owner", 32'(bus.owner_o), 0);
    chk("rst_cyc", 32'(bus.wb_cycle_o), 0);
    chk("rst_stb", 32'(bus.wb_strobe_o), 0);
    chk("rst_we", 32'(bus.wb_we_o), 0);
    chk("rst_addr", 32'(bus.wb_addr_o), 0);
    chk("rst_stall", 32'(bus.ini_stall_o), 32'h3);
    chk("rst_ack", 32'(bus.ini_ack_o), 0);
    chk("rst_timeout", 32'(bus.timeout_o), 0);
    step();
    rst = 1'b0;

    // single read from ini0
    step();
    set_ini(0, 1, 1, 0, 24'h008000, '0);
    push_gnt("t1_grant", 0);
    at_neg();
    chk("t1_pre_stall", 32'(bus.ini_stall_o), 32'h3);
    chk("t1_pre_cyc", 32'(bus.wb_cycle_o), 0);
    step();
    at_neg();
    chk("t1_cyc", 32'(bus.wb_cycle_o), 1);
    chk("t1_addr", 32'(bus.wb_addr_o), 32'h008000);
    chk("t1_stall", 32'(bus.ini_stall_o), 32'h2);
    step();
    set_ini(0, 1, 0, 0, 24'h008000, '0);
    tgt(1, 0, 16'hBEEF);
    push_ack("t1", 2'b01, 16'hBEEF);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(0, 0, 0, 0, '0, '0);
    at_neg();
    chk("t1_drop_cyc", 32'(bus.wb_cycle_o), 0);
    chk("t1_drop_valid", 32'(bus.owner_valid_o), 1);
    step();
    at_neg();
    chk("t1_idle_valid", 32'(bus.owner_valid_o), 0);

    // simultaneous requests after reset
    do_reset();
    step();
    set_ini(0, 1, 1, 0, 24'h000100, '0);
    set_ini(1, 1, 1, 0, 24'h000200, '0);
    push_gnt("t2_grant0", 0);
    push_gnt("t2_grant1", 1);
    at_neg();
    chk("t2_pre_stall", 32'(bus.ini_stall_o), 32'h3);
    step();
    at_neg();
    chk("t2_stall0", 32'(bus.ini_stall_o), 32'h2);
    chk("t2_addr0", 32'(bus.wb_addr_o), 32'h100);
    step();
    set_ini(0, 1, 0, 0, 24'h000100, '0);
    tgt(1, 0, 16'h1111);
    push_ack("t2a", 2'b01, 16'h1111);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(0, 0, 0, 0, '0, '0);
    at_neg();
    chk("t2_drop_cyc", 32'(bus.wb_cycle_o), 0);
    step();
    at_neg();
    chk("t2_gap_valid", 32'(bus.owner_valid_o), 0);
    chk("t2_gap_stall", 32'(bus.ini_stall_o), 32'h3);
    step();
    at_neg();
    chk("t2_owner1", 32'(bus.owner_o), 1);
    chk("t2_addr1", 32'(bus.wb_addr_o), 32'h200);
    chk("t2_stall1", 32'(bus.ini_stall_o), 32'h1);
    step();
    set_ini(1, 1, 0, 0, 24'h000200, '0);
    tgt(1, 0, 16'h2222);
    push_ack("t2b", 2'b10, 16'h2222);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(1, 0, 0, 0, '0, '0);
    step();

    // ini0 4-beat burst while ini1 waits
    do_reset();
    step();
    set_ini(0, 1, 1, 0, 24'h000300, '0);
    set_ini(1, 1, 1, 0, 24'h000900, '0);
    push_gnt("t3_grant0", 0);
    push_gnt("t3_grant1", 1);
    step();
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk($sformatf("t3_stall_b%0d", k),
          32'(bus.ini_stall_o), 32'h2);
      chk($sformatf("t3_addr_b%0d", k),
          32'(bus.wb_addr_o), 32'h300 + k);
      step();
      if (k < 3)
        set_ini(0, 1, 1, 0, 24'(24'h300 + k + 1), '0);
      else
        set_ini(0, 1, 0, 0, 24'h000303, '0);
      tgt(1, 0, 16'(16'hA000 + k));
      push_ack($sformatf("t3_b%0d", k), 2'b01,
               16'(16'hA000 + k));
    end
    at_neg();
    chk("t3_last_stall", 32'(bus.ini_stall_o), 32'h2);
    step();
    tgt(0, 0, '0);
    set_ini(0, 0, 0, 0, '0, '0);
    at_neg();
    chk("t3_drop_cyc", 32'(bus.wb_cycle_o), 0);
    step();
    step();
    at_neg();
    chk("t3_owner1", 32'(bus.owner_o), 1);
    chk("t3_stall1", 32'(bus.ini_stall_o), 32'h1);
    chk("t3_addr1", 32'(bus.wb_addr_o), 32'h900);
    step();
    set_ini(1, 1, 0, 0, 24'h000900, '0);
    tgt(1, 0, 16'h9999);
    push_ack("t3_ini1", 2'b10, 16'h9999);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(1, 0, 0, 0, '0, '0);
    step();

    // target stall passes through to owner
    do_reset();
    step();
    tgt(0, 1, '0);
    set_ini(0, 1, 1, 1, 24'h000400, 16'h5A5A);
    push_gnt("t4_grant", 0);
    step();
    at_neg();
    chk("t4_stall_a", 32'(bus.ini_stall_o), 32'h3);
    chk("t4_stb", 32'(bus.wb_strobe_o), 1);
    chk("t4_we", 32'(bus.wb_we_o), 1);
    chk("t4_wdata", 32'(bus.wb_data_o), 32'h5A5A);
    step();
    at_neg();
    chk("t4_stall_b", 32'(bus.ini_stall_o), 32'h3);
    step();
    tgt(0, 0, '0);
    at_neg();
    chk("t4_unstall", 32'(bus.ini_stall_o), 32'h2);
    step();
    set_ini(0, 1, 0, 1, 24'h000400, 16'h5A5A);
    tgt(1, 0, 16'h0042);
    push_ack("t4", 2'b01, 16'h0042);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(0, 0, 0, 0, '0, '0);
    step();
    step();

    // async reset mid-burst
    do_reset();
    step();
    set_ini(0, 1, 1, 0, 24'h000500, '0);
    set_ini(1, 1, 1, 0, 24'h000600, '0);
    push_gnt("t5_grant0", 0);
    step();
    at_neg();
    chk("t5_pre_cyc", 32'(bus.wb_cycle_o), 1);
    step();
    set_ini(0, 1, 1, 0, 24'h000501, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_cyc", 32'(bus.wb_cycle_o), 0);
    chk("t5_rst_stall", 32'(bus.ini_stall_o), 32'h3);
    chk("t5_rst_valid", 32'(bus.owner_valid_o), 0);
    step();
    rst = 1'b0;
    push_gnt("t5_regrant0", 0);
    push_gnt("t5_grant1", 1);
    at_neg();
    step();
    at_neg();
    chk("t5_re_owner", 32'(bus.owner_o), 0);
    chk("t5_re_addr", 32'(bus.wb_addr_o), 32'h501);
    step();
    set_ini(0, 1, 0, 0, 24'h000501, '0);
    tgt(1, 0, 16'h5555);
    push_ack("t5a", 2'b01, 16'h5555);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(0, 0, 0, 0, '0, '0);
    step();
    step();
    at_neg();
    chk("t5_owner1", 32'(bus.owner_o), 1);
    step();
    set_ini(1, 1, 0, 0, 24'h000600, '0);
    tgt(1, 0, 16'h6666);
    push_ack("t5b", 2'b10, 16'h6666);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(1, 0, 0, 0, '0, '0);
    step();

    // target never acks
    do_reset();
    step();
    set_ini(0, 1, 1, 0, 24'h000700, '0);
    push_gnt("t6_grant", 0);
    step();
    step();
    set_ini(0, 1, 0, 0, 24'h000700, '0);
    at_neg();
    chk("t6_to_start", 32'(bus.timeout_o), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      at_neg();
`ifdef WB_ARB_TIMEOUT_EN
      chk($sformatf("t6_to_c%0d", i),
          32'(bus.timeout_o), (i == 8) ? 1 : 0);
      chk($sformatf("t6_cyc_c%0d", i),
          32'(bus.wb_cycle_o), (i < 8) ? 1 : 0);
`else
      chk($sformatf("t6_to_c%0d", i),
          32'(bus.timeout_o), 0);
      chk($sformatf("t6_valid_c%0d", i),
          32'(bus.owner_valid_o), 1);
`endif
    end
`ifdef WB_ARB_TIMEOUT_EN
    step();
    tgt(1, 0, 16'h7777);
    at_neg();
    chk("t6_pulse_end", 32'(bus.timeout_o), 0);
    chk("t6_drain_stall", 32'(bus.ini_stall_o), 32'h3);
    chk("t6_drain_ack", 32'(bus.ini_ack_o), 0);
    chk("t6_drain_cyc", 32'(bus.wb_cycle_o), 0);
    step();
    tgt(0, 0, '0);
    set_ini(0, 0, 0, 0, '0, '0);
    step();
    at_neg();
    chk("t6_idle_valid", 32'(bus.owner_valid_o), 0);
`else
    step();
    tgt(1, 0, 16'h7777);
    push_ack("t6_late", 2'b01, 16'h7777);
    at_neg();
    step();
    tgt(0, 0, '0);
    set_ini(0, 0, 0, 0, '0, '0);
    step();
    at_neg();
    chk("t6_idle_valid", 32'(bus.owner_valid_o), 0);
`endif

    step();
    step();
    chk("ack_q_left", 32'(ack_q.size()), 0);
    chk("gnt_q_left", 32'(gnt_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
